// File: rtl/std_nbdcache_tag_pkg.sv
// Shared types and width helpers for the dcache tag-array controller.
package std_nbdcache_tag_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    function automatic int unsigned calc_addr_width(input int unsigned num_words);
        return (num_words > 32'd1) ? $clog2(num_words) : 32'd1;
    endfunction

    function automatic int unsigned calc_be_width(input int unsigned data_width,
                                                  input int unsigned byte_width);
        return (data_width + byte_width - 32'd1) / byte_width;
    endfunction

endpackage

// File: rtl/std_nbdcache_tag_rsp_fifo.sv
// Two-entry response FIFO holding masked per-way tag read data.
module std_nbdcache_tag_rsp_fifo #(
    parameter int unsigned Width = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

endmodule

// File: rtl/std_nbdcache_tag_ctrl.sv
// Tag-array port initiator: post-reset tag sweep, then client read/write
// arbitration onto the single-port tag SRAM with a 2-deep read response buffer.
module std_nbdcache_tag_ctrl
    import std_nbdcache_tag_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned WayCount  = 1,
    parameter int unsigned AddrWidth = calc_addr_width(NumWords),
    parameter int unsigned BeWidth   = calc_be_width(DataWidth, ByteWidth)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          init_done_o,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [WayCount-1:0]           req_way_i,
    input  logic [AddrWidth-1:0]          req_addr_i,
    input  logic [DataWidth-1:0]          req_wdata_i,
    input  logic [BeWidth-1:0]            req_be_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [WayCount*DataWidth-1:0] rsp_rdata_o,
    output logic [WayCount-1:0]           mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [BeWidth-1:0]            mem_be_o,
    input  logic [WayCount*DataWidth-1:0] mem_rdata_i
);

    localparam int unsigned          RspWidth = WayCount * DataWidth;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    ctrl_state_e          state_r;
    ctrl_state_e          state_next_s;
    logic [AddrWidth-1:0] sweep_cnt_r;
    logic [AddrWidth-1:0] sweep_cnt_next_s;
    logic                 init_done_r;
    logic                 inflight_r;
    logic [WayCount-1:0]  inflight_way_r;
    logic                 read_accept_s;
    logic [RspWidth-1:0]  push_data_s;
    logic [RspWidth-1:0]  fifo_head_s;
    logic [1:0]           fifo_count_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 fifo_push_s;
    logic                 fifo_pop_s;
    logic                 rsp_pop_s;
    logic [2:0]           occupancy_s;

    assign init_done_o = init_done_r;

    // State, sweep counter and the single outstanding read slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= INIT;
            sweep_cnt_r    <= '0;
            init_done_r    <= 1'b0;
            inflight_r     <= 1'b0;
            inflight_way_r <= '0;
        end else begin
            state_r     <= state_next_s;
            sweep_cnt_r <= sweep_cnt_next_s;
            init_done_r <= (state_next_s == RUN);
            inflight_r  <= read_accept_s;
            if (read_accept_s) begin
                inflight_way_r <= req_way_i;
            end
        end
    end

    // Returning SRAM data is masked so unselected ways read as zero.
    always_comb begin
        push_data_s = '0;
        for (int w = 0; w < int'(WayCount); w++) begin
            if (inflight_way_r[w]) begin
                push_data_s[w*DataWidth +: DataWidth] = mem_rdata_i[w*DataWidth +: DataWidth];
            end else begin
                push_data_s[w*DataWidth +: DataWidth] = '0;
            end
        end
    end

    // An empty FIFO passes the arriving read straight through, giving
    // one-cycle read latency; the credit counts a same-cycle pop as free.
    always_comb begin
        rsp_valid_o = !fifo_empty_s || inflight_r;
        if (!fifo_empty_s) begin
            rsp_rdata_o = fifo_head_s;
        end else if (inflight_r) begin
            rsp_rdata_o = push_data_s;
        end else begin
            rsp_rdata_o = '0;
        end
        rsp_pop_s   = rsp_valid_o && rsp_ready_i;
        fifo_pop_s  = rsp_ready_i && !fifo_empty_s;
        fifo_push_s = inflight_r && !fifo_full_s && !(fifo_empty_s && rsp_ready_i);
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, rsp_pop_s};
    end

    // Next-state, request handshake and SRAM port drive.
    always_comb begin
        state_next_s     = state_r;
        sweep_cnt_next_s = sweep_cnt_r;
        req_ready_o      = 1'b0;
        read_accept_s    = 1'b0;
        mem_req_o        = '0;
        mem_we_o         = 1'b0;
        mem_addr_o       = '0;
        mem_wdata_o      = '0;
        mem_be_o         = '0;
        case (state_r)
            INIT: begin
                if (!rst_i) begin
                    mem_req_o  = '1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = sweep_cnt_r;
                    mem_be_o   = '1;
                    if (sweep_cnt_r == LastAddr) begin
                        sweep_cnt_next_s = '0;
                        state_next_s     = RUN;
                    end else begin
                        sweep_cnt_next_s = sweep_cnt_r + 1'b1;
                    end
                end else begin
                    sweep_cnt_next_s = '0;
                end
            end
            RUN: begin
                if (!rst_i) begin
                    if (req_we_i) begin
                        req_ready_o = 1'b1;
                    end else begin
                        req_ready_o = (occupancy_s < 3'd2);
                    end
                    if (req_valid_i && req_ready_o) begin
                        mem_req_o  = req_way_i;
                        mem_we_o   = req_we_i;
                        mem_addr_o = req_addr_i;
                        if (req_we_i) begin
                            mem_wdata_o = req_wdata_i;
                            mem_be_o    = req_be_i;
                        end else begin
                            read_accept_s = 1'b1;
                        end
                    end
                end else begin
                    req_ready_o = 1'b0;
                end
            end
            default: begin
                state_next_s     = INIT;
                sweep_cnt_next_s = '0;
            end
        endcase
    end

    std_nbdcache_tag_rsp_fifo #(
        .Width (RspWidth)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push_s),
        .push_data (push_data_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule
